// File: rtl/rs422_frame_pkg.sv
// Shared types and defaults for the RS422 framed-command node.
//   parse_state_t : command frame parser states
//   tx_state_t    : acknowledge transmitter states
//   DEF_*         : default bit timing, header and tail bytes
//   ACK_LEN       : acknowledge frame length in bytes
//   ack_byte()    : selects the acknowledge byte for a given position
package rs422_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    WAIT_HDR1,
    PAYLOAD,
    CMD,
    TAIL_CHK
  } parse_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } tx_state_t;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam logic [7:0]  DEF_HDR0         = 8'hAA;
  localparam logic [7:0]  DEF_HDR1         = 8'h55;
  localparam logic [7:0]  DEF_TAIL         = 8'hEF;
  localparam int unsigned ACK_LEN          = 4;

  // Acknowledge frame layout: HDR0, HDR1, command, checksum.
  function automatic logic [7:0] ack_byte(input logic [1:0] idx,
                                          input logic [7:0] h0,
                                          input logic [7:0] h1,
                                          input logic [7:0] cmd,
                                          input logic [7:0] csum);
    case (idx)
      2'd0:    return h0;
      2'd1:    return h1;
      2'd2:    return cmd;
      default: return csum;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// MSB-first UART byte receiver (1 start, 8 data, 1 stop, no parity).
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx          : serial line, idle high (synchronised internally)
//   byte_valid  : one-cycle strobe when a byte with a valid stop bit arrives
//   byte_data   : received byte, stable from byte_valid until the next byte
// A low stop bit discards the byte and waits for the line to go high again.
module uart_byte_rx
  import rs422_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tick_half, tick_full;

  assign rx_s      = sync_q[1];
  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == FULL_M1);
  assign byte_data = shift_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:      if (!rx_s) state_d = RX_START;
      RX_START:     if (tick_half) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (tick_full && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:      if (tick_full) state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
      default:      state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      // Restarting on every state change aligns the half-bit start sample,
      // after which full-bit periods land on each mid-bit.
      if (state_d != state_q || tick_full) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + 1'b1;
      if (state_q == RX_START) begin
        bit_q <= '0;
      end else if (state_q == RX_DATA && tick_full) begin
        bit_q   <= bit_q + 1'b1;
        shift_q <= {shift_q[6:0], rx_s};
      end
      byte_valid <= (state_q == RX_STOP) && tick_full && rx_s;
    end
  end

endmodule

// File: rtl/rs422_frame_node.sv
// RS422 framed-command node: parses HDR0 HDR1 <payload> CMD TAIL frames and
// answers each valid frame with HDR0 HDR1 CMD CHECKSUM.
//   clk_in          : system clock
//   rst_in_n        : asynchronous active-low reset
//   rs422_ro_main   : receiver output (RX line), idle high
//   rs422_di_main   : driver input (TX line), idle high
//   rs422_de_main   : driver enable, high while an acknowledge is on the line
//   rs422_re_n_main : receiver enable (active-low), always 0
// Optional: define FRAME_TIMEOUT_EN to abort partial frames after an idle gap
// of TIMEOUT_CLKS clocks.
module rs422_frame_node
  import rs422_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0]  HDR0         = DEF_HDR0,
  parameter logic [7:0]  HDR1         = DEF_HDR1,
  parameter logic [7:0]  TAIL         = DEF_TAIL,
  parameter int unsigned PAYLOAD_LEN  = 5
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CLKS = 320
`endif
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic rs422_ro_main,
  output logic rs422_di_main,
  output logic rs422_de_main,
  output logic rs422_re_n_main
);

  localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN + 1);
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);

  logic       rx_valid;
  logic [7:0] rx_data;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk_in),
    .rst_n     (rst_in_n),
    .rx        (rs422_ro_main),
    .byte_valid(rx_valid),
    .byte_data (rx_data)
  );

  assign rs422_re_n_main = 1'b0;

  // ---------------------------------------------------------------- parser
  parse_state_t     ps_q, ps_d;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       csum_q;
  logic [7:0]       cmd_q;
  logic             frame_ok;
  logic             timeout_hit;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TMR_W-1:0] tmr_q;

  assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT_CLKS));

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)                      tmr_q <= '0;
    else if (rx_valid || ps_q == HUNT)  tmr_q <= '0;
    else if (!timeout_hit)              tmr_q <= tmr_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    ps_d     = ps_q;
    frame_ok = 1'b0;
    if (rx_valid) begin
      unique case (ps_q)
        HUNT:      if (rx_data == HDR0) ps_d = WAIT_HDR1;
        WAIT_HDR1: begin
          if (rx_data == HDR1)      ps_d = PAYLOAD;
          else if (rx_data != HDR0) ps_d = HUNT;
        end
        PAYLOAD:   if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) ps_d = CMD;
        CMD:       ps_d = TAIL_CHK;
        TAIL_CHK: begin
          ps_d     = HUNT;
          frame_ok = (rx_data == TAIL);
        end
        default:   ps_d = HUNT;
      endcase
    end else if (timeout_hit) begin
      ps_d = HUNT;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      ps_q   <= HUNT;
      idx_q  <= '0;
      csum_q <= '0;
      cmd_q  <= '0;
    end else begin
      ps_q <= ps_d;
      if ((ps_q == WAIT_HDR1 && ps_d == PAYLOAD) || timeout_hit) begin
        idx_q  <= '0;
        csum_q <= '0;
      end else if (rx_valid && ps_q == PAYLOAD) begin
        idx_q  <= idx_q + 1'b1;
        csum_q <= csum_q + rx_data;
      end
      if (rx_valid && ps_q == CMD) cmd_q <= rx_data;
    end
  end

  // ----------------------------------------------------------- transmitter
  tx_state_t     tx_q, tx_d;
  logic [CW-1:0] clk_cnt_q;
  logic [3:0]    bit_idx_q;
  logic [1:0]    byte_idx_q;
  logic [7:0]    ack_cmd_q, ack_csum_q;
  logic [7:0]    ack_cur;
  logic          bit_done;
  logic          last_bit;
  logic          tx_bit;

  assign bit_done = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx_q == 4'd9);

  always_comb begin
    tx_d = tx_q;
    unique case (tx_q)
      IDLE:    if (frame_ok) tx_d = LEAD;
      LEAD:    if (bit_done) tx_d = SHIFT;
      SHIFT:   if (bit_done && last_bit && byte_idx_q == 2'(ACK_LEN - 1)) tx_d = TRAIL;
      TRAIL:   if (bit_done) tx_d = IDLE;
      default: tx_d = IDLE;
    endcase
  end

  // Bit slot 0 is the start bit, 1..8 carry data MSB first, 9 is the stop bit.
  always_comb begin
    ack_cur = ack_byte(byte_idx_q, HDR0, HDR1, ack_cmd_q, ack_csum_q);
    if (bit_idx_q == 4'd0) tx_bit = 1'b0;
    else if (last_bit)     tx_bit = 1'b1;
    else                   tx_bit = ack_cur[3'(4'd8 - bit_idx_q)];
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      tx_q          <= IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      byte_idx_q    <= '0;
      ack_cmd_q     <= '0;
      ack_csum_q    <= '0;
      rs422_di_main <= 1'b1;
      rs422_de_main <= 1'b0;
    end else begin
      tx_q <= tx_d;
      if (tx_q == IDLE || bit_done) clk_cnt_q <= '0;
      else                          clk_cnt_q <= clk_cnt_q + 1'b1;
      if (tx_q == IDLE) begin
        bit_idx_q  <= '0;
        byte_idx_q <= '0;
        // Frames completing while an acknowledge is in flight are dropped.
        if (frame_ok) begin
          ack_cmd_q  <= cmd_q;
          ack_csum_q <= csum_q;
        end
      end else if (tx_q == SHIFT && bit_done) begin
        if (last_bit) begin
          bit_idx_q  <= '0;
          byte_idx_q <= byte_idx_q + 1'b1;
        end else begin
          bit_idx_q <= bit_idx_q + 1'b1;
        end
      end
      // Pins are registered so DE and DI share the same one-cycle lag.
      rs422_di_main <= (tx_q == SHIFT) ? tx_bit : 1'b1;
      rs422_de_main <= (tx_q != IDLE);
    end
  end

endmodule

// File: tb/tb_rs422_frame_node.sv
`timescale 1ns/1ps
module tb_rs422_frame_node;

  logic clk_in = 1'b0;
  logic rst_in_n = 1'b0;
  logic rs422_ro_main = 1'b1;
  logic rs422_di_main, rs422_de_main, rs422_re_n_main;

  rs422_frame_node dut (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .rs422_ro_main  (rs422_ro_main),
    .rs422_di_main  (rs422_di_main),
    .rs422_de_main  (rs422_de_main),
    .rs422_re_n_main(rs422_re_n_main)
  );

  always #31 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_cnt  = 0;
  int          de_rises = 0;
  int          exp_acks = 0;
  logic [31:0] ack_word = '0;
  logic        framing_good = 1'b0;
  logic        hold_good = 1'b0;
  logic        fall_good = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Captures each acknowledge from the pins: start bit 16 clocks after DE,
  // 40 bits at 16 clocks/bit, DE dropping 16 clocks after the last stop bit.
  initial begin : ack_monitor
    logic [39:0] samp;
    logic        aborted;
    forever begin
      @(posedge rs422_de_main);
      de_rises++;
      aborted = 1'b0;
      samp    = '0;
      @(negedge clk_in);
      repeat (24) @(negedge clk_in);
      for (int unsigned k = 0; k < 40; k++) begin
        if (!rs422_de_main) begin
          aborted = 1'b1;
          break;
        end
        samp[k] = rs422_di_main;
        if (k < 39) repeat (16) @(negedge clk_in);
      end
      if (!aborted) begin
        repeat (22) @(negedge clk_in);
        hold_good = rs422_de_main;
        repeat (4) @(negedge clk_in);
        fall_good = !rs422_de_main && rs422_di_main;
        framing_good = 1'b1;
        for (int unsigned b = 0; b < 4; b++) begin
          if (samp[10*b] !== 1'b0 || samp[10*b+9] !== 1'b1) framing_good = 1'b0;
          for (int unsigned j = 0; j < 8; j++)
            ack_word[31-8*b-j] = samp[10*b+1+j];
        end
        ack_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rs422_ro_main = 1'b0;
    repeat (16) @(negedge clk_in);
    for (int unsigned i = 0; i < 8; i++) begin
      rs422_ro_main = b[7-i];
      repeat (16) @(negedge clk_in);
    end
    rs422_ro_main = stop;
    repeat (16) @(negedge clk_in);
    if (!stop) begin
      rs422_ro_main = 1'b1;
      repeat (32) @(negedge clk_in);
    end
  endtask

  // Bytes are packed right-aligned; the first byte sent is the leftmost.
  task automatic send_seq(input logic [95:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    rs422_ro_main = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_acks(input string tag);
    int unsigned cyc = 0;
    while (ack_cnt < exp_acks && cyc < 3000) begin
      @(negedge clk_in);
      cyc++;
    end
    check(tag, ack_cnt, exp_acks);
  endtask

  task automatic check_ack(input string tag, input logic [31:0] exp);
    wait_acks({tag, "_count"});
    check({tag, "_data"}, ack_word, exp);
    check({tag, "_framing"}, {31'd0, framing_good}, 32'd1);
    check({tag, "_de_hold"}, {31'd0, hold_good}, 32'd1);
    check({tag, "_de_fall"}, {31'd0, fall_good}, 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk_in);
    check("rst_di", {31'd0, rs422_di_main}, 32'd1);
    check("rst_de", {31'd0, rs422_de_main}, 32'd0);
    check("rst_re_n", {31'd0, rs422_re_n_main}, 32'd0);
    rst_in_n = 1'b1;
    idle(40);

    // Junk then a valid frame
    send_seq({8'h01, 8'h02, 8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h02, 8'hEF}, 11);
    exp_acks = 1;
    check_ack("frame1", 32'hAA55_020F);
    check("re_n_const", {31'd0, rs422_re_n_main}, 32'd0);
    idle(40);

    // Stray byte before the header
    send_seq({8'h08, 8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'hEF}, 10);
    exp_acks = 2;
    check_ack("frame2", 32'hAA55_010F);
    idle(40);

    // Bad tail: no response, then a valid frame recovers
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'h0F}, 9);
    idle(800);
    check("badtail_no_de", de_rises, 2);
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'hEF}, 9);
    exp_acks = 3;
    check_ack("after_badtail", 32'hAA55_030F);
    idle(40);

    // Truncated frame followed by a long gap
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03}, 5);
    idle(1600);
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01, 8'hEF}, 9);
`ifdef FRAME_TIMEOUT_EN
    exp_acks = 4;
    check_ack("trunc_timeout", 32'hAA55_010F);
`else
    idle(800);
    check("trunc_no_ack", ack_cnt, exp_acks);
    check("trunc_no_de", de_rises, exp_acks);
`endif
    idle(40);

    // Framing error inside a frame: byte dropped, frame never completes
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03}, 5);
    send_byte(8'h04, 1'b0);
    send_seq({8'h05, 8'h01, 8'hEF}, 3);
    idle(800);
    check("framerr_no_de", de_rises, exp_acks);
    // Push the parser out of a pending tail check
    send_byte(8'h00, 1'b1);
    idle(40);

    // Sub-half-bit glitch between payload bytes must not count as a byte
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03}, 5);
    idle(20);
    rs422_ro_main = 1'b0;
    repeat (4) @(negedge clk_in);
    idle(48);
    send_seq({8'h04, 8'h05, 8'h04, 8'hEF}, 4);
    exp_acks++;
    check_ack("glitch", 32'hAA55_040F);
    idle(40);

    // Reset in the middle of an acknowledge
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05, 8'hEF}, 9);
    begin
      int unsigned cyc = 0;
      while (!rs422_de_main && cyc < 200) begin
        @(negedge clk_in);
        cyc++;
      end
    end
    check("midack_de_up", {31'd0, rs422_de_main}, 32'd1);
    repeat (200) @(negedge clk_in);
    #7 rst_in_n = 1'b0;
    #1;
    check("midack_rst_di", {31'd0, rs422_di_main}, 32'd1);
    check("midack_rst_de", {31'd0, rs422_de_main}, 32'd0);
    repeat (4) @(negedge clk_in);
    rst_in_n = 1'b1;
    idle(800);
    check("midack_aborted", ack_cnt, exp_acks);
    send_seq({8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hEF}, 9);
    exp_acks++;
    check_ack("after_reset", 32'hAA55_060F);
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs422_frame_node.md
Name: rs422_frame_node

Overview:
- Single-channel RS422 framed-command node.
- Receives MSB-first UART bytes on rs422_ro_main and parses fixed-length command frames.
- On every valid frame, transmits a 4-byte acknowledge frame on rs422_di_main, driving the transceiver direction pins.
- Sits directly at the chip pins as the top-level link endpoint.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (16 MHz clock, 1 Mbaud).
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h55, second header byte.
- TAIL, 8'hEF, frame terminator byte.
- PAYLOAD_LEN, 5, payload bytes between header and command byte.
- TIMEOUT_CLKS, 320, idle gap (20 bit times) that aborts a partial frame.

Ports:
- clk_in  input  1  system clock, 16 MHz.
- rst_in_n  input  1  asynchronous active-low reset.
- rs422_ro_main  input  1  receiver output (RX line), idle high.
- rs422_di_main  output  1  driver input (TX line), idle high.
- rs422_de_main  output  1  driver enable, high while transmitting.
- rs422_re_n_main  output  1  receiver enable, active-low; constant 0 (always listening).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk_in, rst_in_n).
- Reset values: rs422_di_main=1, rs422_de_main=0, rs422_re_n_main=0; all FSMs idle; counters zero.
- RX input: 2-flop synchronised before use.
- UART format (RX and TX): 1 start bit (0), 8 data bits MSB first (bit7 first), 1 stop bit (1), no parity.
- RX byte detection:
  - Falling edge while idle starts reception.
  - Start bit re-sampled at CLKS_PER_BIT/2; if high, treat as glitch and return to idle.
  - Each data bit sampled at its mid-bit.
  - Stop bit sampled mid-bit: if 1, emit a one-cycle byte strobe; if 0, discard the byte (framing error) and wait for line high before re-arming.
- Parser FSM (one transition per byte strobe):
  - HUNT: HDR0 -> WAIT_HDR1; anything else -> stay.
  - WAIT_HDR1: HDR1 -> PAYLOAD (index=0); HDR0 -> stay; else -> HUNT.
  - PAYLOAD: store byte, add to 8-bit checksum (mod 256); after PAYLOAD_LEN bytes -> CMD.
  - CMD: latch command byte -> TAIL_CHK.
  - TAIL_CHK: byte==TAIL -> pulse frame_ok and go HUNT; else go HUNT with no response. A mismatched tail byte is not re-examined as HDR0.
  - Checksum clears on entry to PAYLOAD.
- Acknowledge TX:
  - On frame_ok with transmitter idle: latch cmd and checksum; within 2 clocks raise rs422_de_main.
  - One bit time later, send AA, 55, cmd, checksum back-to-back with no inter-byte idle.
  - Hold DE one bit time after the final stop bit, then drop DE; di stays 1.
- frame_ok while TX busy: frame is dropped; no queueing.
- RX and parser operate independently of TX (full duplex).
- Reset mid-byte or mid-frame: all state aborts immediately; TX line returns to 1 and DE to 0 asynchronously.

Optional Feature:
- Macro FRAME_TIMEOUT_EN.
- Defined: counter counts clocks since the last byte strobe while the parser is outside HUNT. Reaching TIMEOUT_CLKS forces HUNT and clears the partial frame; a new HDR0 after the gap resyncs cleanly.
- Undefined: no timer; resync only through header hunting. A truncated frame can consume bytes of the following frame.

Decomposition:
- Package rs422_frame_pkg: parser state enum (HUNT, WAIT_HDR1, PAYLOAD, CMD, TAIL_CHK), TX state enum (IDLE, LEAD, SHIFT, TRAIL), default header/tail constants, ACK_LEN=4.
- One sub-module, uart_byte_rx: synchroniser, bit timing, byte strobe and framing error.
- Parser and transmitter stay in the top-level.

Test Plan:
- Valid frame: bytes 01 02 (junk) then AA 55 01 02 03 04 05 02 EF -> DE rises, TX sends AA 55 02 0F MSB-first at 16 clk/bit, DE falls one bit after last stop.
- Second frame AA 55 01 02 03 04 05 01 EF preceded by stray 08 -> ack AA 55 01 0F; stray byte ignored.
- Bad tail: AA 55 01 02 03 04 05 01 0F -> no DE assertion; next valid frame still acknowledged.
- Truncated frame: AA 55 01 02 03, 100 us idle, then AA 55 01 02 03 04 05 01 EF -> with FRAME_TIMEOUT_EN, ack AA 55 01 0F; without it, no ack.
- Framing error: byte with stop bit 0 inside a frame -> byte dropped, frame incomplete, no ack; glitch shorter than half a bit on idle line -> no byte strobe.
- Reset asserted mid-ack transmission -> di=1, de=0 immediately; after release, a valid frame is acknowledged normally.
